// File: rtl/ura_hazard_controller_pkg.sv
// ura_hazard_controller_pkg: URA constants, forward codes, slot record and match/age helpers
package ura_hazard_controller_pkg;
  localparam int REC_URA_W = 7;
  localparam logic [REC_URA_W-1:0] URA_NONE = 7'd0;
  localparam logic [REC_URA_W-1:0] URA_HI = 7'b1000000;
  localparam logic [REC_URA_W-1:0] URA_LO = 7'b1000001;
  localparam logic [1:0] URA_CP0_PFX = 2'b01;
  typedef enum logic [1:0] {FWD_GRF, FWD_E, FWD_M, FWD_W} fwd_e;
  typedef struct packed {
    logic valid;
    logic [REC_URA_W-1:0] ura0;
    logic [REC_URA_W-1:0] ura1;
    logic [1:0] tnew;
    logic md;
    logic md_div;
  } rec_t;
  typedef struct packed {
    fwd_e sel;
    logic hz;
  } src_res_t;
  function automatic rec_t age(rec_t r);
    age = r;
    age.tnew = (r.tnew != 2'd0) ? r.tnew - 2'd1 : 2'd0;
  endfunction
  function automatic logic hit(rec_t r, logic [REC_URA_W-1:0] s);
    return r.valid && s != URA_NONE && (s == r.ura0 || s == r.ura1);
  endfunction
  function automatic src_res_t resolve(rec_t e, rec_t m, rec_t w, logic [REC_URA_W-1:0] s, logic [1:0] tuse);
    logic he, hm, hw, any;
    logic [1:0] tn;
    fwd_e code;
    he = hit(e, s);
    hm = hit(m, s);
    hw = hit(w, s);
    any = he || hm || hw;
    tn = he ? e.tnew : hm ? m.tnew : w.tnew;
    code = he ? FWD_E : hm ? FWD_M : FWD_W;
    resolve.sel = (any && tn == 2'd0) ? code : FWD_GRF;
    resolve.hz = any && tn > tuse;
  endfunction
endpackage

// File: rtl/ura_hazard_controller_if.sv
// ura_hazard_controller_if: D-stage hazard query bundle; master drives D/flush, slave returns stall/fwd/md_busy
interface ura_hazard_controller_if #(parameter int URA_W = 7);
  logic flush;
  logic d_valid;
  logic [URA_W-1:0] d_rs_ura;
  logic [1:0] d_rs_tuse;
  logic [URA_W-1:0] d_rt_ura;
  logic [1:0] d_rt_tuse;
  logic [URA_W-1:0] d_wr_ura0;
  logic [URA_W-1:0] d_wr_ura1;
  logic [1:0] d_tnew;
  logic d_md_start;
  logic d_md_is_div;
  logic d_uses_hilo;
  logic stall;
  logic [1:0] fwd_rs_sel;
  logic [1:0] fwd_rt_sel;
  logic md_busy;
  modport master (
    output flush, d_valid, d_rs_ura, d_rs_tuse, d_rt_ura, d_rt_tuse, d_wr_ura0, d_wr_ura1,
           d_tnew, d_md_start, d_md_is_div, d_uses_hilo,
    input  stall, fwd_rs_sel, fwd_rt_sel, md_busy
  );
  modport slave (
    input  flush, d_valid, d_rs_ura, d_rs_tuse, d_rt_ura, d_rt_tuse, d_wr_ura0, d_wr_ura1,
           d_tnew, d_md_start, d_md_is_div, d_uses_hilo,
    output stall, fwd_rs_sel, fwd_rt_sel, md_busy
  );
endinterface

// File: rtl/ura_hazard_controller_md_busy_timer.sv
// ura_hazard_controller_md_busy_timer: mult/div countdown; load+kind start it, busy while count != 0
module ura_hazard_controller_md_busy_timer #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES = 10
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  input  logic kind,
  output logic busy
);
  localparam int MAX_CYCLES = (DIV_CYCLES > MULT_CYCLES) ? DIV_CYCLES : MULT_CYCLES;
  localparam int CW = $clog2(MAX_CYCLES + 1);
  logic [CW-1:0] count_q, count_d;
  always_comb begin
    count_d = load ? (kind ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES))
                   : (count_q != '0) ? count_q - CW'(1) : count_q;
  end
  always_ff @(posedge clk) begin
    if (reset) count_q <= '0;
    else count_q <= count_d;
  end
  assign busy = count_q != '0;
endmodule

// File: rtl/ura_hazard_controller.sv
// ura_hazard_controller: E/M/W destination tracking, stall and D-stage forward select; ports clk, reset, hz (slave)
module ura_hazard_controller
  import ura_hazard_controller_pkg::*;
#(
  parameter int URA_W = 7,
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES = 10
) (
  input  logic clk,
  input  logic reset,
  ura_hazard_controller_if.slave hz
);
  rec_t e_q, m_q, w_q, e_d, m_d, w_d, d_rec;
  src_res_t rs_res, rt_res;
  logic [URA_W-1:0] rs_ura, rt_ura;
  logic md_busy, md_hold, stall;
  assign rs_ura = hz.d_rs_ura;
  assign rt_ura = hz.d_rt_ura;
  always_comb begin
    d_rec = '{valid: hz.d_valid, ura0: hz.d_wr_ura0, ura1: hz.d_wr_ura1, tnew: hz.d_tnew,
              md: hz.d_md_start, md_div: hz.d_md_is_div};
    rs_res = resolve(e_q, m_q, w_q, rs_ura, hz.d_rs_tuse);
    rt_res = resolve(e_q, m_q, w_q, rt_ura, hz.d_rt_tuse);
    // an md op still in E has not loaded the timer yet, so it blocks HI/LO users too
    md_hold = (md_busy || (e_q.valid && e_q.md)) && (hz.d_uses_hilo || hz.d_md_start);
    stall = hz.d_valid && (rs_res.hz || rt_res.hz || md_hold);
    e_d = (hz.d_valid && !stall && !hz.flush) ? d_rec : '0;
    m_d = hz.flush ? '0 : age(e_q);
    w_d = age(m_q);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      e_q <= '0;
      m_q <= '0;
      w_q <= '0;
    end else begin
      e_q <= e_d;
      m_q <= m_d;
      w_q <= w_d;
    end
  end
  ura_hazard_controller_md_busy_timer #(.MULT_CYCLES(MULT_CYCLES), .DIV_CYCLES(DIV_CYCLES)) u_md (
    .clk(clk),
    .reset(reset),
    .load(e_q.valid && e_q.md && !hz.flush),
    .kind(e_q.md_div),
    .busy(md_busy)
  );
  assign hz.stall = stall;
  assign hz.fwd_rs_sel = rs_res.sel;
  assign hz.fwd_rt_sel = rt_res.sel;
  assign hz.md_busy = md_busy;
endmodule
